// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM measurement block and its consumer.
// The consumer (master) drives the enable and the raw waveform and
// receives the measured period/high time plus status pulses.
interface pwm_capture_if #(
    parameter int MAX_PERIOD = 100_000_000
);
    localparam int CW = $clog2(MAX_PERIOD + 1);

    logic          enable;
    logic          pwm_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          timeout;
    logic          locked;

    modport master (
        output enable,
        output pwm_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout,
        input  locked
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output period,
        output high_time,
        output valid,
        output timeout,
        output locked
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement.
// The asynchronous waveform is synchronized, edge-detected, and a single
// saturating counter measures rise-to-rise (period) and rise-to-fall
// (high time) intervals. A waveform stuck at one level for MAX_PERIOD
// cycles reports a timeout with 0 % or 100 % duty.
module pwm_capture #(
    parameter int MAX_PERIOD = 100_000_000
) (
    input  logic          clock,
    input  logic          reset,
    pwm_capture_if.slave  bus
);
    localparam int            CW      = $clog2(MAX_PERIOD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PERIOD);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    // Input conditioning
    logic [1:0] sync_reg;     // two-flop synchronizer, [1] is the usable value
    logic       delay_reg;    // one more stage for edge detection
    logic [1:0] fill_reg;     // tracks when sync_reg[1] holds a real sample
    logic       armed_reg;    // a genuine low has been seen since reset
    logic       rise;
    logic       fall;

    // Measurement state
    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] high_cnt_reg;
    logic [CW-1:0] period_reg;
    logic [CW-1:0] high_time_reg;
    logic          valid_reg;
    logic          timeout_reg;
    logic          locked_reg;
    logic [CW-1:0] count_inc;
    logic          at_max;

    // Synchronize the waveform and arm edge detection only after a real low
    // sample, so a waveform already high when reset releases is not a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg  <= 2'b00;
            delay_reg <= 1'b0;
            fill_reg  <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], bus.pwm_in};
            delay_reg <= sync_reg[1];
            fill_reg  <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && !sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rise = sync_reg[1] & ~delay_reg & armed_reg;
    assign fall = ~sync_reg[1] & delay_reg;

    // Counter saturates so it can never wrap past MAX_PERIOD.
    assign at_max    = (count_reg == MAX_CNT);
    assign count_inc = at_max ? MAX_CNT : count_reg + ONE;

    // Measurement FSM with registered outputs; edges win over a timeout
    // that would otherwise fire in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            high_cnt_reg  <= '0;
            period_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            if (!bus.enable) begin
                state_reg  <= IDLE;
                count_reg  <= '0;
                locked_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        count_reg <= '0;
                        if (rise) begin
                            state_reg <= HIGH;
                            count_reg <= ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            high_cnt_reg <= count_reg;
                            count_reg    <= count_inc;
                            state_reg    <= LOW;
                        end else if (at_max) begin
                            period_reg    <= MAX_CNT;
                            high_time_reg <= MAX_CNT;
                            valid_reg     <= 1'b1;
                            timeout_reg   <= 1'b1;
                            locked_reg    <= 1'b0;
                            state_reg     <= STUCK;
                        end else begin
                            count_reg <= count_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period_reg    <= count_reg;
                            high_time_reg <= high_cnt_reg;
                            valid_reg     <= 1'b1;
                            locked_reg    <= 1'b1;
                            count_reg     <= ONE;
                            state_reg     <= HIGH;
                        end else if (at_max) begin
                            period_reg    <= MAX_CNT;
                            high_time_reg <= '0;
                            valid_reg     <= 1'b1;
                            timeout_reg   <= 1'b1;
                            locked_reg    <= 1'b0;
                            state_reg     <= STUCK;
                        end else begin
                            count_reg <= count_inc;
                        end
                    end
                    STUCK: begin
                        if (rise) begin
                            count_reg <= ONE;
                            state_reg <= HIGH;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.period    = period_reg;
    assign bus.high_time = high_time_reg;
    assign bus.valid     = valid_reg;
    assign bus.timeout   = timeout_reg;
    assign bus.locked    = locked_reg;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with MAX_PERIOD = 20.
module tb_pwm_capture;
    localparam int MAXP = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    pwm_capture_if #(.MAX_PERIOD(MAXP)) bus ();

    pwm_capture #(.MAX_PERIOD(MAXP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Pulse bookkeeping sampled on the falling edge
    int cyc    = 0;
    int vcount = 0;
    int tcount = 0;
    int both   = 0;
    int last_v = -1;
    int gap    = 0;
    int vrun   = 0;
    int vmax   = 0;
    int trun   = 0;
    int tmax   = 0;

    // Count valid/timeout pulses, their widths and the valid spacing
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (bus.valid === 1'b1) begin
            vcount = vcount + 1;
            if (last_v >= 0) gap = cyc - last_v;
            last_v = cyc;
            vrun = vrun + 1;
            if (vrun > vmax) vmax = vrun;
        end else begin
            vrun = 0;
        end
        if (bus.timeout === 1'b1) begin
            tcount = tcount + 1;
            trun = trun + 1;
            if (trun > tmax) tmax = trun;
        end else begin
            trun = 0;
        end
        if (bus.valid === 1'b1 && bus.timeout === 1'b1) both = both + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_periods(input int n, input int hi, input int lo);
        repeat (n) begin
            bus.pwm_in = 1'b1;
            step(hi);
            bus.pwm_in = 1'b0;
            step(lo);
        end
    endtask

    int v0, t0, b0;

    initial begin
        bus.enable = 1'b1;
        bus.pwm_in = 1'b0;
        reset      = 1'b0;
        step(3);
        check("rst_period",    bus.period,    0);
        check("rst_high_time", bus.high_time, 0);
        check("rst_valid",     bus.valid,     0);
        check("rst_timeout",   bus.timeout,   0);
        check("rst_locked",    bus.locked,    0);
        reset = 1'b1;
        step(2);

        // Steady 3 high / 5 low
        v0 = vcount; t0 = tcount;
        run_periods(1, 3, 5);
        check("a_first_rise_no_valid", vcount - v0, 0);
        check("a_unlocked_first",      bus.locked,  0);
        run_periods(3, 3, 5);
        check("a_valid_count",  vcount - v0, 3);
        check("a_no_timeout",   tcount - t0, 0);
        check("a_period",       bus.period,    8);
        check("a_high_time",    bus.high_time, 3);
        check("a_locked",       bus.locked,    1);
        check("a_valid_gap",    gap,           8);
        $display("seg A: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        // Rise, high 4, then held low -> 0 % duty timeout
        v0 = vcount; t0 = tcount; b0 = both;
        bus.pwm_in = 1'b1;
        step(4);
        bus.pwm_in = 1'b0;
        step(30);
        check("b_valid_count",   vcount - v0, 2);
        check("b_timeout_count", tcount - t0, 1);
        check("b_together",      both - b0,   1);
        check("b_period",        bus.period,    20);
        check("b_high_time",     bus.high_time, 0);
        check("b_locked",        bus.locked,    0);
        $display("seg B: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        // Held high from STUCK -> 100 % duty timeout, then recover
        v0 = vcount; t0 = tcount;
        bus.pwm_in = 1'b1;
        step(30);
        check("c_valid_count",   vcount - v0, 1);
        check("c_timeout_count", tcount - t0, 1);
        check("c_period",        bus.period,    20);
        check("c_high_time",     bus.high_time, 20);
        check("c_locked",        bus.locked,    0);
        bus.pwm_in = 1'b0;
        step(5);
        v0 = vcount;
        run_periods(1, 3, 5);
        check("c_stuck_rise_no_valid", vcount - v0, 0);
        check("c_still_unlocked",      bus.locked,  0);
        run_periods(2, 3, 5);
        check("c_recover_valids", vcount - v0, 2);
        check("c_recover_period", bus.period,    8);
        check("c_recover_high",   bus.high_time, 3);
        check("c_recover_locked", bus.locked,    1);
        $display("seg C: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        // 10 / 10 waveform: period equals MAX_PERIOD, must not time out
        v0 = vcount; t0 = tcount;
        run_periods(3, 10, 10);
        check("d_valid_count", vcount - v0, 3);
        check("d_no_timeout",  tcount - t0, 0);
        check("d_period",      bus.period,    20);
        check("d_high_time",   bus.high_time, 10);
        check("d_locked",      bus.locked,    1);
        $display("seg D: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        // Back to 3/5 (first rise lands exactly at counter == MAX_PERIOD)
        v0 = vcount; t0 = tcount;
        run_periods(3, 3, 5);
        check("e_valid_count", vcount - v0, 3);
        check("e_edge_at_max", tcount - t0, 0);
        check("e_period",      bus.period,    8);
        check("e_high_time",   bus.high_time, 3);
        // Disable mid-period while the waveform keeps toggling
        bus.enable = 1'b0;
        v0 = vcount; t0 = tcount;
        run_periods(2, 3, 5);
        check("e_dis_no_valid",   vcount - v0, 0);
        check("e_dis_no_timeout", tcount - t0, 0);
        check("e_dis_locked",     bus.locked,    0);
        check("e_dis_period",     bus.period,    8);
        check("e_dis_high",       bus.high_time, 3);
        bus.enable = 1'b1;
        run_periods(1, 3, 5);
        check("e_reen_no_valid", vcount - v0, 0);
        run_periods(2, 3, 5);
        check("e_reen_valids", vcount - v0, 2);
        check("e_reen_period", bus.period,    8);
        check("e_reen_locked", bus.locked,    1);
        $display("seg E: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        // Asynchronous reset during LOW with the waveform toggling
        v0 = vcount; t0 = tcount;
        bus.pwm_in = 1'b1;
        step(1);
        #2;
        reset = 1'b0;
        #1;
        check("f_async_period", bus.period,    0);
        check("f_async_high",   bus.high_time, 0);
        check("f_async_locked", bus.locked,    0);
        check("f_async_valid",  bus.valid,     0);
        bus.pwm_in = 1'b0;
        step(2);
        bus.pwm_in = 1'b1;
        step(2);
        reset = 1'b1;
        step(10);
        check("f_no_valid",   vcount - v0, 0);
        check("f_no_timeout", tcount - t0, 0);
        check("f_period_zero", bus.period, 0);
        bus.pwm_in = 1'b0;
        step(5);
        run_periods(1, 3, 5);
        check("f_high_at_release_ignored", vcount - v0, 0);
        run_periods(2, 3, 5);
        check("f_resume_valids", vcount - v0, 2);
        check("f_resume_period", bus.period,    8);
        check("f_resume_high",   bus.high_time, 3);
        check("f_resume_locked", bus.locked,    1);
        check("f_valid_gap",     gap,           8);
        $display("seg F: period=%0d high=%0d locked=%0d", bus.period, bus.high_time, bus.locked);

        check("valid_one_cycle",   vmax, 1);
        check("timeout_one_cycle", tmax, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
